ifetch_axi_master: RTL and testbench
====================================

Name: ifetch_axi_master

Overview:
- AXI-style read initiator feeding the front end. Accepts fetch requests (PC) from the PC/branch unit and issues single-beat read transactions on the instruction-memory AR channel.
- Collects R-channel data into a 2-entry instruction buffer and presents {pc, instr, err} to decode with valid/ready.
- Supports pipeline flush with discard of in-flight responses.

Parameters:
- WIDTH, 32, address/data/PC width.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2).
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_pc  in  WIDTH  byte address of instruction (bits [1:0] ignored).
- req_ready  out  1  request accepted when req_valid & req_ready.
- flush  in  1  discard buffer and in-flight fetch; has priority over req.
- arvalid  out  1  read address valid.
- araddr  out  WIDTH  word index = {2'b00, pc[WIDTH-1:2]}.
- arburst  out  2  constant 2'b00.
- arsize  out  3  constant 3'd2 (4 bytes).
- arlen  out  8  constant 8'd0 (single beat).
- arready  in  1  slave address ready.
- rvalid  in  1  read data valid.
- rdata  in  WIDTH  instruction word.
- rlast  in  1  last beat; must be 1 (single beat).
- rresp  in  2  response; nonzero = error.
- rready  out  1  initiator accepts data.
- out_valid  out  1  buffered instruction valid.
- out_pc  out  WIDTH  PC of head entry.
- out_instr  out  WIDTH  instruction of head entry.
- out_err  out  1  head entry had rresp!=0 or rlast==0.
- out_ready  in  1  decode consumes head.

Behaviour:
- Reset (async, rst_n low): state=IDLE, arvalid=0, araddr=0, rready=0, buffer empty, out_valid=0, out_pc=0, out_instr=0, out_err=0, req_ready=0. Constants arburst/arsize/arlen are driven regardless of reset.
- At most one outstanding transaction.
- Credit: count = buffer occupancy + (1 if in ADDR/DATA).
- req_ready = (state==IDLE) & (count < BUF_DEPTH) & !flush.
- FSM states:
  - IDLE: on req_valid & req_ready, latch pc, drive araddr, arvalid=1 -> ADDR (registered, so arvalid rises the cycle after acceptance).
  - ADDR: arvalid, araddr held stable until arvalid & arready. Then arvalid=0, rready=1 -> DATA. On flush in ADDR: set drop flag, keep arvalid stable; on handshake go to DROP instead of DATA.
  - DATA: rready=1. On rvalid, write {pc, rdata, (rresp!=0)|!rlast} to buffer tail, rready=0 -> IDLE. Buffer space is guaranteed by credit. On flush while in DATA (no rvalid that cycle) -> DROP.
  - DROP: rready=1. On rvalid, discard beat -> IDLE. If flush and rvalid coincide in DATA, the beat is discarded -> IDLE.
- Latency: req accepted at cycle N; arvalid visible N+1. With arready=1 and slave rvalid one cycle after the address handshake, out_valid at N+3 at earliest.
- Buffer: circular FIFO with wrapping pointers. Head pop on out_valid & out_ready. Simultaneous push and pop allowed, including when full (pop frees the slot first). Outputs show the head entry directly.
- flush: empties buffer in the same edge (out_valid=0 next cycle). Ignores out_ready that cycle. A request in the same cycle is not accepted.
- rvalid outside DATA/DROP is ignored (rready=0).

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - 8-bit-min counter runs while in ADDR or DATA; resets on state entry.
  - On reaching TIMEOUT_CYC in DATA: push entry with out_err=1, out_instr=0, -> DROP (late beat discarded).
  - In ADDR, arvalid is never withdrawn (AXI rule); the counter only saturates.
- Undefined: no counter, no timeout logic; waits indefinitely.

Decomposition:
- Shared package/defines: WIDTH, AXI constants BURST_FIXED=2'b00, SIZE_4B=3'd2, RESP_OKAY=2'd0, FSM state encodings (IDLE, ADDR, DATA, DROP).
- Natural sub-module: ifetch_buf (parameterized synchronous FIFO with push/pop/flush, count output).

Test Plan:
- Reset then req_pc=0x10, slave arready=1, rdata=0x00500093, rresp=0 -> araddr=0x4, arlen=0, arsize=2; out_valid with out_pc=0x10, out_instr=0x00500093, out_err=0.
- Back-to-back reqs 0x0,0x4,0x8 with out_ready=0 -> two entries buffered, req_ready=0 for third. Assert out_ready -> third issued; order 0x0,0x4,0x8 preserved.
- Slave holds arready=0 for 3 cycles -> arvalid=1 and araddr stable throughout; proceeds after arready.
- Flush while in DATA (rvalid delayed 2 cycles) -> late beat consumed with rready=1, never appears on out_*. Next req 0x20 returns its own data.
- rresp=2'd2 on fetch of 0x40 -> entry out_pc=0x40, out_err=1.
- (FETCH_TIMEOUT_EN, TIMEOUT_CYC=8) slave never asserts rvalid -> after 8 cycles in DATA, out_err=1 entry emitted, state DROP.

Source files
------------

// File: rtl/ifetch_axi_master_pkg.sv
// Shared types and AXI constants for the instruction-fetch read initiator.
// Optional watchdog is enabled by defining FETCH_TIMEOUT_EN.
package ifetch_axi_master_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'd2;
  localparam logic [7:0] LEN_1BEAT   = 8'd0;
  localparam logic [1:0] RESP_OKAY   = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_e;

endpackage

// File: rtl/ifetch_buf.sv
// Circular instruction buffer with wrapping pointers and same-edge flush.
// The head entry is presented combinationally from storage.
module ifetch_buf
  import ifetch_axi_master_pkg::*;
#(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         full;
  logic         do_pop;
  logic         do_push;

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & !empty_o;
  // a pop frees the slot first, so a full buffer can still take a push
  assign do_push = push_i & (!full | do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_axi_master.sv
// Single-outstanding AXI read initiator feeding decode through ifetch_buf.
// Define FETCH_TIMEOUT_EN to add the DATA-phase watchdog.
module ifetch_axi_master
  import ifetch_axi_master_pkg::*;
#(
  parameter int WIDTH       = XLEN,
  parameter int BUF_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_pc,
  output logic             req_ready,
  input  logic             flush,
  output logic             arvalid,
  output logic [WIDTH-1:0] araddr,
  output logic [1:0]       arburst,
  output logic [2:0]       arsize,
  output logic [7:0]       arlen,
  input  logic             arready,
  input  logic             rvalid,
  input  logic [WIDTH-1:0] rdata,
  input  logic             rlast,
  input  logic [1:0]       rresp,
  output logic             rready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_err,
  input  logic             out_ready
);

  localparam int  EW     = 2*WIDTH + 1;
  localparam int  CW     = $clog2(BUF_DEPTH) + 1;
  localparam bit  CFG_OK = (BUF_DEPTH >= 2) && (TIMEOUT_CYC > 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] araddr_q, araddr_d;
  logic             drop_q, drop_d;

  logic             push;
  logic             pop;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             empty;
  logic [CW-1:0]    occ;
  logic [CW:0]      credit;
  logic             inflight;
  logic             accept;
  logic             to_hit;

  assign arburst = BURST_FIXED;
  assign arsize  = SIZE_4B;
  assign arlen   = LEN_1BEAT;
  assign araddr  = araddr_q;

  assign inflight  = (state_q == S_ADDR) | (state_q == S_DATA);
  assign credit    = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign req_ready = rst_n & CFG_OK & (state_q == S_IDLE)
                   & (credit < (CW+1)'(BUF_DEPTH)) & !flush;
  assign accept    = req_valid & req_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC+1) > 8) ? $clog2(TIMEOUT_CYC+1) : 8;
  logic [TW-1:0] tmr_q, tmr_d;

  // fires in the TIMEOUT_CYC-th cycle spent in DATA
  assign to_hit = (state_q == S_DATA) & (tmr_q >= TW'(TIMEOUT_CYC-1));

  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) tmr_d = '0;
    else if (inflight && tmr_q != '1) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      araddr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      araddr_q <= araddr_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    araddr_d = araddr_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_ADDR;
        pc_d     = req_pc;
        araddr_d = {2'b00, req_pc[WIDTH-1:2]};
        drop_d   = 1'b0;
      end
      S_ADDR: begin
        // address stays up across a flush; the beat is dropped later
        if (flush) drop_d = 1'b1;
        if (arready) state_d = (drop_q | flush) ? S_DROP : S_DATA;
      end
      S_DATA: begin
        if (rvalid)               state_d = S_IDLE;
        else if (flush || to_hit) state_d = S_DROP;
      end
      S_DROP: if (rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (state_q == S_ADDR);
    rready    = (state_q == S_DATA) | (state_q == S_DROP);
    push      = 1'b0;
    push_data = {pc_q, rdata, (rresp != RESP_OKAY) | !rlast};
    if (state_q == S_DATA && !flush) begin
      if (rvalid) begin
        push = 1'b1;
      end else if (to_hit) begin
        push      = 1'b1;
        push_data = {pc_q, {WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  assign pop = !empty & out_ready & !flush;

  ifetch_buf #(
    .W     (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .empty_o (empty),
    .count_o (occ)
  );

  assign out_valid = !empty;
  assign {out_pc, out_instr, out_err} = head;

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Bench for ifetch_axi_master: directed table, corner sequences, random run.
// The watchdog sequence is compiled in only with FETCH_TIMEOUT_EN.
module tb_ifetch_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, flush;
  logic [31:0] req_pc;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        rvalid = 1'b0, rlast = 1'b1, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        out_valid, out_err, out_ready;
  logic [31:0] out_pc, out_instr;

  always #5 clk = ~clk;

  ifetch_axi_master #(.WIDTH(32), .BUF_DEPTH(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .flush(flush),
    .arvalid(arvalid), .araddr(araddr), .arburst(arburst),
    .arsize(arsize), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rresp(rresp),
    .rready(rready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_err(out_err), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] romw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // slave agent configuration (written only by the main sequence)
  int          sl_ar_hold = 0;
  int          sl_rdly = 0;
  bit          sl_fixed = 1'b0;
  bit          sl_err_en = 1'b0;
  logic [31:0] sl_data = '0;
  logic [1:0]  sl_resp = '0;
  logic        sl_last = 1'b1;

  bit          ar_hs = 1'b0, r_hs = 1'b0, have = 1'b0;
  int          ar_cnt = 0, rcnt = 0;
  logic [31:0] cap = '0, nd = '0;
  logic [1:0]  nr = '0;
  logic        nl = 1'b1;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      arready = 1'b0; rvalid = 1'b0; have = 1'b0; ar_cnt = 0;
    end else begin
      if (r_hs) rvalid = 1'b0;
      if (ar_hs) begin
        arready = 1'b0; ar_cnt = 0; have = 1'b1;
        rcnt = (sl_rdly < 0) ? int'($urandom_range(0, 3)) : sl_rdly;
        if (sl_fixed) begin
          nd = sl_data; nr = sl_resp; nl = sl_last;
        end else begin
          nd = romw(cap);
          nr = (sl_err_en && $urandom_range(0, 7) == 0) ? 2'd2 : 2'd0;
          nl = !(sl_err_en && $urandom_range(0, 15) == 0);
        end
      end else if (arvalid && !arready) begin
        if (sl_ar_hold < 0) arready = ($urandom_range(0, 2) != 0);
        else if (ar_cnt >= sl_ar_hold) arready = 1'b1;
        else ar_cnt++;
      end
      if (have && !rvalid) begin
        if (rcnt == 0) begin
          rvalid = 1'b1; rdata = nd; rresp = nr; rlast = nl; have = 1'b0;
        end else rcnt--;
      end
    end
    #1;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    cap   = araddr;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          arh;
    int          rd;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    sl_fixed = 1'b1; sl_ar_hold = v.arh; sl_rdly = v.rd;
    sl_data = v.data; sl_resp = v.resp; sl_last = v.last;
    @(negedge clk);
    req_valid = 1'b1; req_pc = v.pc;
    #1 chk("vec_req_ready", 32'(req_ready), 1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1 lat++;
      if (lat == 1) chk("vec_arvalid_rise", 32'(arvalid), 1);
      if (arvalid) chk("vec_araddr", araddr, v.pc >> 2);
      if (out_valid) seen = 1'b1;
    end
    chk("vec_latency", lat, v.lat);
    chk("vec_out_pc", out_pc, v.pc);
    chk("vec_out_instr", out_instr, v.data);
    chk("vec_out_err", 32'(out_err), 32'(v.err));
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    #1 chk("vec_popped", 32'(out_valid), 0);
  endtask

  task automatic issue(input logic [31:0] pc, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_pc = pc;
    for (int k = 0; k < 12 && !ok; k++) begin
      #1;
      if (req_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk) req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok, any, acc, seen, ovs, cons;
    bit m_busy, m_aph, m_drop, exp_rdy, hs_ar, hs_r;
    logic [31:0] m_pc;
    logic [31:0] e3[3];
    int k, d;
    ent_t mq[$];

    vt[0] = '{32'h10,  32'h0050_0093, 2'd0, 1'b1, 0, 0, 1'b0, 3};
    vt[1] = '{32'h40,  32'h0010_0073, 2'd2, 1'b1, 0, 1, 1'b1, 4};
    vt[2] = '{32'h7C,  32'hDEAD_BEEF, 2'd0, 1'b0, 0, 0, 1'b1, 3};
    vt[3] = '{32'h100, 32'h1234_5678, 2'd0, 1'b1, 3, 0, 1'b0, 6};
    vt[4] = '{32'h204, 32'hCAFE_F00D, 2'd3, 1'b1, 1, 2, 1'b1, 6};
    vt[5] = '{32'h20,  32'h00A0_0113, 2'd0, 1'b1, 0, 0, 1'b0, 3};
    e3[0] = 32'h0; e3[1] = 32'h4; e3[2] = 32'h8;

    req_valid = 1'b0; req_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_arburst", 32'(arburst), 0);
    chk("rst_arsize", 32'(arsize), 2);
    chk("rst_arlen", 32'(arlen), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // back-to-back: two entries fill the buffer, third must wait
    sl_fixed = 1'b0; sl_err_en = 1'b0; sl_ar_hold = 0; sl_rdly = 0;
    for (int i = 0; i < 2; i++) begin
      issue(e3[i], ok);
      chk("b2b_accept", 32'(ok), 1);
    end
    @(negedge clk);
    req_valid = 1'b1; req_pc = e3[2]; any = 1'b0;
    repeat (8) begin
      #1 any |= req_ready;
      @(negedge clk);
    end
    chk("b2b_full_block", 32'(any), 0);
    #1 chk("b2b_head_pc", out_pc, e3[0]);
    @(negedge clk);
    out_ready = 1'b1; k = 0; acc = 1'b0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      #1;
      if (out_valid) begin
        chk("b2b_order_pc", out_pc, e3[k]);
        chk("b2b_order_instr", out_instr, romw(e3[k] >> 2));
        k++;
      end
      if (req_valid && req_ready) acc = 1'b1;
      @(negedge clk);
      if (acc) req_valid = 1'b0;
    end
    chk("b2b_count", k, 3);
    out_ready = 1'b0; req_valid = 1'b0;

    // flush while waiting for a late beat
    sl_rdly = 2;
    issue(32'h30, ok);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (rready) seen = 1'b1;
      else @(negedge clk);
    end
    chk("fl_data_phase", 32'(seen), 1);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    ovs = 1'b0; cons = 1'b0;
    repeat (12) begin
      #1;
      ovs |= out_valid;
      cons |= rvalid && rready;
      @(negedge clk);
    end
    chk("fl_no_out", 32'(ovs), 0);
    chk("fl_beat_consumed", 32'(cons), 1);
    run_vec(vt[5]);

    // flush empties buffer and blocks a same-cycle request
    sl_fixed = 1'b0; sl_rdly = 0; sl_ar_hold = 0;
    issue(32'h60, ok);
    repeat (3) @(negedge clk);
    #1 chk("flb_has_entry", 32'(out_valid), 1);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h64;
    #1 chk("flb_req_blocked", 32'(req_ready), 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 chk("flb_empty", 32'(out_valid), 0);
    chk("flb_no_issue", 32'(arvalid), 0);

`ifdef FETCH_TIMEOUT_EN
    sl_rdly = 20;
    issue(32'h50, ok);
    d = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (out_valid) seen = 1'b1;
      else begin
        if (rready) d++;
        @(negedge clk);
      end
    end
    chk("to_cycles", d, 8);
    chk("to_err", 32'(out_err), 1);
    chk("to_instr", out_instr, 0);
    chk("to_pc", out_pc, 32'h50);
    chk("to_drop_rready", 32'(rready), 1);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    ovs = 1'b0;
    repeat (30) begin
      #1 ovs |= out_valid;
      @(negedge clk);
    end
    chk("to_late_dropped", 32'(ovs), 0);
`endif

    // random traffic against a transaction-level model
    do_reset();
    sl_fixed = 1'b0; sl_err_en = 1'b1; sl_ar_hold = -1; sl_rdly = -1;
    m_busy = 1'b0; m_aph = 1'b0; m_drop = 1'b0; m_pc = '0;
    mq.delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 1) == 1);
      req_pc    = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = !m_busy && (mq.size() < 2) && !flush;
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_arvalid", 32'(arvalid), 32'(m_aph));
      chk("rnd_rready", 32'(rready), 32'(m_busy && !m_aph));
      if (m_aph) chk("rnd_araddr", araddr, m_pc >> 2);
      if (mq.size() != 0) begin
        chk("rnd_out_pc", out_pc, mq[0].pc);
        chk("rnd_out_instr", out_instr, mq[0].instr);
        chk("rnd_out_err", 32'(out_err), 32'(mq[0].err));
      end
      hs_ar = m_aph && arready;
      hs_r  = m_busy && !m_aph && rvalid;
      if (flush) begin
        mq.delete();
        if (m_busy) m_drop = 1'b1;
      end else if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
      end
      if (hs_r) begin
        m_busy = 1'b0;
        if (!m_drop && !flush)
          mq.push_back('{m_pc, romw(m_pc >> 2), (rresp != 2'd0) || !rlast});
      end
      if (hs_ar) m_aph = 1'b0;
      if (exp_rdy && req_valid) begin
        m_busy = 1'b1; m_aph = 1'b1; m_drop = 1'b0; m_pc = req_pc;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
